// File: rtl/seq_pkg.sv
// Shared types and opcode constants for the SM83-style instruction sequencer.
package seq_pkg;
    typedef enum logic [1:0] {
        COND_NZ = 2'd0,
        COND_Z  = 2'd1,
        COND_NC = 2'd2,
        COND_C  = 2'd3
    } cond_t;

    typedef struct packed {
        logic z;
        logic n;
        logic h;
        logic c;
    } flags_t;

    localparam logic [7:0] PREFIX_OPCODE = 8'hCB;
    localparam logic [7:0] IRQ_OPCODE    = 8'hD3;
    localparam int         STEP_W_DEF    = 3;
endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder for the interrupt request lines.
module irq_prio_enc #(
    parameter int  NUM_IRQ = 5,
    localparam int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic               any,
    output logic [IDX_W-1:0]   idx,
    output logic [NUM_IRQ-1:0] onehot
);
    assign any = |req;

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        idx    = '0;
        onehot = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx       = IDX_W'(i);
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/op_sequencer.sv
// Instruction sequencer: IR latch, micro-step counter, CB prefix, HALT, IME/EI delay, IRQ dispatch.
// Define SEQ_HALT_BUG_EN to model the SM83 HALT bug (double read of the byte after HALT).
module op_sequencer #(
    parameter int         STEP_W        = seq_pkg::STEP_W_DEF,
    parameter int         NUM_IRQ       = 5,
    parameter logic [7:0] PREFIX_OPCODE = seq_pkg::PREFIX_OPCODE,
    parameter logic [7:0] IRQ_OPCODE    = seq_pkg::IRQ_OPCODE,
    localparam int        IDX_W         = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               done,
    input  logic               is_cond,
    input  logic [1:0]         cond,
    input  logic [3:0]         flags,
    input  logic [STEP_W-1:0]  next_cond,
    input  logic [7:0]         d_in,
    input  logic               halt_req,
    input  logic               ime_set,
    input  logic               ime_clr,
    input  logic [NUM_IRQ-1:0] irq_req,
    output logic [7:0]         ir,
    output logic [STEP_W-1:0]  step,
    output logic               prefix,
    output logic               ime,
    output logic               halted,
    output logic               irq_active,
    output logic [IDX_W-1:0]   irq_idx,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic               seq_err,
    output logic               pc_inc_inhibit
);
    import seq_pkg::*;

`ifdef SEQ_HALT_BUG_EN
    localparam bit HALT_BUG = 1'b1;
`else
    localparam bit HALT_BUG = 1'b0;
`endif

    localparam logic [STEP_W-1:0] STEP_MAX = '1;

    flags_t               fl;
    logic                 matched;
    logic                 irq_any;
    logic [IDX_W-1:0]     enc_idx;
    logic [NUM_IRQ-1:0]   enc_onehot;
    logic                 ei_pend, ime_nxt, ei_nxt;
    logic                 halt_bug, enter_halt, pfx_case, dispatch;
    logic                 unused_nh;

    assign fl        = flags_t'(flags);
    assign unused_nh = ^{fl.n, fl.h};

    always_comb begin
        matched = 1'b0;
        case (cond_t'(cond))
            COND_NZ: matched = !fl.z;
            COND_Z:  matched =  fl.z;
            COND_NC: matched = !fl.c;
            COND_C:  matched =  fl.c;
            default: matched = 1'b0;
        endcase
    end

    irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_enc (
        .req    (irq_req),
        .any    (irq_any),
        .idx    (enc_idx),
        .onehot (enc_onehot)
    );

    // The prefix suffix is never split from its CB byte by an interrupt.
    assign halt_bug   = HALT_BUG && !halted && done && halt_req && !ime && irq_any;
    assign enter_halt = !halted && done && halt_req && !halt_bug;
    assign pfx_case   = !halted && done && !halt_req && (ir == PREFIX_OPCODE) && !prefix;
    assign dispatch   = halted ? (irq_any && ime)
                               : (done && !halt_req && !pfx_case && ime && irq_any);

    // EI takes effect at a done only after that done's dispatch check used the old ime.
    always_comb begin
        ime_nxt = ime;
        ei_nxt  = ei_pend;
        if (dispatch) begin
            ime_nxt = 1'b0;
            ei_nxt  = 1'b0;
        end else if (!halted && done && (ei_pend || ime_set)) begin
            ime_nxt = 1'b1;
            ei_nxt  = 1'b0;
        end else if (ime_set) begin
            ei_nxt = 1'b1;
        end
        if (ime_clr) begin
            ime_nxt = 1'b0;
            ei_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ir             <= 8'h00;
            step           <= '0;
            prefix         <= 1'b0;
            ime            <= 1'b0;
            ei_pend        <= 1'b0;
            halted         <= 1'b0;
            irq_active     <= 1'b0;
            irq_idx        <= '0;
            irq_ack        <= '0;
            seq_err        <= 1'b0;
            pc_inc_inhibit <= 1'b0;
        end else if (stall) begin
            irq_ack <= '0;
        end else begin
            irq_ack        <= '0;
            pc_inc_inhibit <= 1'b0;
            ime            <= ime_nxt;
            ei_pend        <= ei_nxt;
            if (halted || done) begin
                step <= '0;
                if (halted && irq_any) halted <= 1'b0;
                if (enter_halt) begin
                    halted <= 1'b1;
                end else if (pfx_case) begin
                    ir     <= d_in;
                    prefix <= 1'b1;
                end else if (dispatch) begin
                    ir         <= IRQ_OPCODE;
                    prefix     <= 1'b0;
                    irq_active <= 1'b1;
                    irq_idx    <= enc_idx;
                    irq_ack    <= enc_onehot;
                end else if (!halted || irq_any) begin
                    ir             <= d_in;
                    prefix         <= 1'b0;
                    irq_active     <= 1'b0;
                    pc_inc_inhibit <= halt_bug;
                end
            end else if (is_cond && !matched) begin
                step <= next_cond;
            end else if (step == STEP_MAX) begin
                seq_err <= 1'b1;
            end else begin
                step <= step + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_op_sequencer.sv
// Directed table plus randomized run of op_sequencer against a behavioural reference model.
module tb_op_sequencer;
`ifdef SEQ_HALT_BUG_EN
    localparam bit HALT_BUG = 1'b1;
`else
    localparam bit HALT_BUG = 1'b0;
`endif
    localparam int NUM_IRQ  = 5;
    localparam int STEP_MAX = 7;

    typedef struct {
        bit         rst, stall, done, is_cond;
        logic [1:0] cond;
        logic [3:0] flags;
        logic [2:0] nxt;
        logic [7:0] d_in;
        bit         halt_req, ime_set, ime_clr;
        logic [4:0] irq;
    } in_t;

    typedef struct {
        in_t        i;
        logic [7:0] e_ir;
        int         e_step;
        bit         e_pfx, e_ime, e_halt;
        logic [4:0] e_ack;
        bit         e_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, stall, done, is_cond, halt_req, ime_set, ime_clr;
    logic [1:0] cond;
    logic [3:0] flags;
    logic [2:0] next_cond, step, irq_idx;
    logic [7:0] d_in, ir;
    logic [4:0] irq_req, irq_ack;
    logic       prefix, ime, halted, irq_active, seq_err, pc_inc_inhibit;

    always #5 clk = ~clk;

    op_sequencer dut (
        .clk(clk), .rst(rst), .stall(stall), .done(done), .is_cond(is_cond),
        .cond(cond), .flags(flags), .next_cond(next_cond), .d_in(d_in),
        .halt_req(halt_req), .ime_set(ime_set), .ime_clr(ime_clr), .irq_req(irq_req),
        .ir(ir), .step(step), .prefix(prefix), .ime(ime), .halted(halted),
        .irq_active(irq_active), .irq_idx(irq_idx), .irq_ack(irq_ack),
        .seq_err(seq_err), .pc_inc_inhibit(pc_inc_inhibit)
    );

    int n_vec = 0, n_bad = 0, cyc_no = 0;

    // Reference model state
    logic [7:0] m_ir;
    int         m_step, m_idx;
    bit         m_pfx, m_ime, m_ei, m_halt, m_act, m_err, m_pci;
    logic [4:0] m_ack;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL cycle %0d %s: got %0h expected %0h", cyc_no, nm, act, exp);
        end
    endtask

    task automatic fetch(input logic [7:0] b);
        m_ir = b; m_pfx = 0; m_act = 0;
    endtask

    task automatic model_tick(input in_t v);
        bit any, hb, take, flag, match, old_ime, old_ei, old_halt;
        if (!v.rst) begin
            m_ir = 0; m_step = 0; m_pfx = 0; m_ime = 0; m_ei = 0; m_halt = 0;
            m_act = 0; m_idx = 0; m_ack = 0; m_err = 0; m_pci = 0;
            return;
        end
        if (v.stall) begin
            m_ack = 0;
            return;
        end
        any = (v.irq != 0);
        old_ime = m_ime; old_ei = m_ei; old_halt = m_halt;
        flag  = v.cond[1] ? v.flags[0] : v.flags[3];
        match = v.cond[0] ? flag : !flag;
        hb    = HALT_BUG && !m_halt && v.done && v.halt_req && !m_ime && any;
        take = 0; m_ack = 0; m_pci = 0;
        if (m_halt) begin
            if (any) begin
                m_halt = 0;
                if (old_ime) take = 1; else fetch(v.d_in);
            end
        end else if (v.done) begin
            m_step = 0;
            if (v.halt_req && !hb) m_halt = 1;
            else if (m_ir == 8'hCB && !m_pfx) begin m_ir = v.d_in; m_pfx = 1; end
            else if (old_ime && any) take = 1;
            else begin fetch(v.d_in); m_pci = hb; end
        end else if (v.is_cond && !match) m_step = v.nxt;
        else if (m_step == STEP_MAX) m_err = 1;
        else m_step++;
        if (take) begin
            m_idx = 0;
            for (int k = NUM_IRQ - 1; k >= 0; k--) if (v.irq[k]) m_idx = k;
            m_ir = 8'hD3; m_pfx = 0; m_act = 1; m_ack = 5'(1 << m_idx);
            m_ime = 0; m_ei = 0;
        end else if (!old_halt && v.done && (old_ei || v.ime_set)) begin
            m_ime = 1; m_ei = 0;
        end else if (v.ime_set) m_ei = 1;
        if (v.ime_clr) begin m_ime = 0; m_ei = 0; end
    endtask

    task automatic cyc(input in_t v);
        @(negedge clk);
        rst = v.rst; stall = v.stall; done = v.done; is_cond = v.is_cond;
        cond = v.cond; flags = v.flags; next_cond = v.nxt; d_in = v.d_in;
        halt_req = v.halt_req; ime_set = v.ime_set; ime_clr = v.ime_clr; irq_req = v.irq;
        @(posedge clk);
        model_tick(v);
        #1;
        cyc_no++;
        chk("ir", 32'(ir), 32'(m_ir));
        chk("step", 32'(step), 32'(m_step));
        chk("prefix", 32'(prefix), 32'(m_pfx));
        chk("ime", 32'(ime), 32'(m_ime));
        chk("halted", 32'(halted), 32'(m_halt));
        chk("irq_active", 32'(irq_active), 32'(m_act));
        chk("irq_idx", 32'(irq_idx), 32'(m_idx));
        chk("irq_ack", 32'(irq_ack), 32'(m_ack));
        chk("seq_err", 32'(seq_err), 32'(m_err));
        chk("pc_inc_inhibit", 32'(pc_inc_inhibit), 32'(m_pci));
    endtask

    function automatic vec_t mk(input bit r, s, dn, ic, input logic [1:0] cd, input logic [3:0] fl,
                                input logic [2:0] nx, input logic [7:0] d, input bit h, st, cl,
                                input logic [4:0] iq, input logic [7:0] eir, input int estep,
                                input bit epf, eime, ehlt, input logic [4:0] eack, input bit eerr);
        vec_t t;
        t.i = '{rst: r, stall: s, done: dn, is_cond: ic, cond: cd, flags: fl, nxt: nx, d_in: d,
                halt_req: h, ime_set: st, ime_clr: cl, irq: iq};
        t.e_ir = eir; t.e_step = estep; t.e_pfx = epf; t.e_ime = eime;
        t.e_halt = ehlt; t.e_ack = eack; t.e_err = eerr;
        return t;
    endfunction

    vec_t tbl[$];
    in_t  rv;

    initial begin
        // reset
        tbl.push_back(mk(0,0,0,0,0,4'h0,0,8'h00,0,0,0,5'h00, 8'h00,0,0,0,0,5'h00,0));
        // conditional branch: JR NZ with z=1 fails -> next_cond, with z=0 increments
        tbl.push_back(mk(1,0,1,0,0,4'h0,0,8'h20,0,0,0,5'h00, 8'h20,0,0,0,0,5'h00,0));
        tbl.push_back(mk(1,0,0,1,0,4'h8,3,8'h00,0,0,0,5'h00, 8'h20,3,0,0,0,5'h00,0));
        tbl.push_back(mk(1,0,1,0,0,4'h0,0,8'h20,0,0,0,5'h00, 8'h20,0,0,0,0,5'h00,0));
        tbl.push_back(mk(1,0,0,1,0,4'h0,3,8'h00,0,0,0,5'h00, 8'h20,1,0,0,0,5'h00,0));
        // stall holds for three cycles with done asserted, then the fetch lands
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(1,1,1,0,0,4'h0,0,8'hAA,0,0,0,5'h00, 8'h20,1,0,0,0,5'h00,0));
        tbl.push_back(mk(1,0,1,0,0,4'h0,0,8'hAA,0,0,0,5'h00, 8'hAA,0,0,0,0,5'h00,0));
        // EI delay: no dispatch at EI's done, dispatch of index 2 at the next done
        tbl.push_back(mk(1,0,1,0,0,4'h0,0,8'h00,0,1,0,5'h14, 8'h00,0,0,1,0,5'h00,0));
        tbl.push_back(mk(1,0,1,0,0,4'h0,0,8'h11,0,0,0,5'h14, 8'hD3,0,0,0,0,5'h04,0));
        tbl.push_back(mk(1,0,1,0,0,4'h0,0,8'h22,0,0,0,5'h00, 8'h22,0,0,0,0,5'h00,0));
        // prefix atomicity
        tbl.push_back(mk(1,0,1,0,0,4'h0,0,8'hCB,0,1,0,5'h00, 8'hCB,0,0,1,0,5'h00,0));
        tbl.push_back(mk(1,0,1,0,0,4'h0,0,8'h37,0,0,0,5'h01, 8'h37,0,1,1,0,5'h00,0));
        tbl.push_back(mk(1,0,1,0,0,4'h0,0,8'h44,0,0,0,5'h01, 8'hD3,0,0,0,0,5'h01,0));
        // HALT with ime=0, done ignored while halted, wake on request without dispatch
        tbl.push_back(mk(1,0,1,0,0,4'h0,0,8'h55,1,0,0,5'h00, 8'hD3,0,0,0,1,5'h00,0));
        tbl.push_back(mk(1,0,1,0,0,4'h0,0,8'h66,0,0,0,5'h00, 8'hD3,0,0,0,1,5'h00,0));
        tbl.push_back(mk(1,0,0,0,0,4'h0,0,8'h77,0,0,0,5'h08, 8'h77,0,0,0,0,5'h00,0));
        // step overflow: climbs to 7, then holds and flags seq_err
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(1,0,0,0,0,4'h0,0,8'h00,0,0,0,5'h00, 8'h77,(k < 7) ? k + 1 : 7,0,0,0,5'h00,k == 7));
        // reset mid-dispatch, then reset while halted
        tbl.push_back(mk(1,0,1,0,0,4'h0,0,8'h00,0,1,0,5'h00, 8'h00,0,0,1,0,5'h00,1));
        tbl.push_back(mk(1,0,1,0,0,4'h0,0,8'h88,0,0,0,5'h02, 8'hD3,0,0,0,0,5'h02,1));
        tbl.push_back(mk(0,0,1,0,0,4'h0,0,8'h88,0,0,0,5'h02, 8'h00,0,0,0,0,5'h00,0));
        tbl.push_back(mk(1,0,1,0,0,4'h0,0,8'h99,1,0,0,5'h00, 8'h00,0,0,0,1,5'h00,0));
        tbl.push_back(mk(0,0,0,0,0,4'h0,0,8'h00,0,0,0,5'h00, 8'h00,0,0,0,0,5'h00,0));

        foreach (tbl[n]) begin
            cyc(tbl[n].i);
            chk("tbl.ir", 32'(ir), 32'(tbl[n].e_ir));
            chk("tbl.step", 32'(step), 32'(tbl[n].e_step));
            chk("tbl.prefix", 32'(prefix), 32'(tbl[n].e_pfx));
            chk("tbl.ime", 32'(ime), 32'(tbl[n].e_ime));
            chk("tbl.halted", 32'(halted), 32'(tbl[n].e_halt));
            chk("tbl.irq_ack", 32'(irq_ack), 32'(tbl[n].e_ack));
            chk("tbl.seq_err", 32'(seq_err), 32'(tbl[n].e_err));
        end

        for (int n = 0; n < 4000; n++) begin
            rv.rst      = ($urandom_range(63) != 0);
            rv.stall    = ($urandom_range(4) == 0);
            rv.done     = ($urandom_range(2) == 0);
            rv.is_cond  = ($urandom_range(1) == 1);
            rv.cond     = 2'($urandom_range(3));
            rv.flags    = 4'($urandom_range(15));
            rv.nxt      = 3'($urandom_range(7));
            rv.d_in     = ($urandom_range(5) == 0) ? 8'hCB : 8'($urandom_range(255));
            rv.halt_req = rv.done && ($urandom_range(7) == 0);
            rv.ime_set  = ($urandom_range(7) == 0);
            rv.ime_clr  = ($urandom_range(11) == 0);
            rv.irq      = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'd0;
            cyc(rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/op_sequencer.md
Name: op_sequencer

Overview:
- Parametrised instruction sequencer for the SM83-style core, sitting between the memory data bus and the opcode decoder.
- Latches IR and advances the micro-step counter, taking direction from the decoder's done/is_cond/next_cond outputs.
- Beyond plain fetch/step it handles memory wait states, the CB prefix, HALT, the IME flag with EI delay, and interrupt dispatch by injecting a pseudo-opcode.

Parameters:
- STEP_W, 3, width of step counter; valid micro-steps 0..2^STEP_W-1.
- NUM_IRQ, 5, number of interrupt request lines; index 0 is highest priority.
- PREFIX_OPCODE, 8'hCB, opcode that marks the following opcode as a prefixed (CB-table) opcode.
- IRQ_OPCODE, 8'hD3, unused opcode injected into IR to run the interrupt-dispatch microcode.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- stall  in  1  memory not ready; freeze all state this cycle.
- done  in  1  decoder: current opcode finishes this cycle.
- is_cond  in  1  decoder: branch on cond this step.
- cond  in  2  condition code: NZ=0, Z=1, NC=2, C=3.
- flags  in  4  {z,n,h,c} from the flag register.
- next_cond  in  STEP_W  step to load if the condition fails.
- d_in  in  8  data bus (opcode byte at PC).
- halt_req  in  1  decoder: HALT executing (valid with done).
- ime_set  in  1  decoder: EI executing.
- ime_clr  in  1  decoder: DI or dispatch.
- irq_req  in  NUM_IRQ  requests, already masked by IE.
- ir  out  8  instruction register.
- step  out  STEP_W  current micro-step.
- prefix  out  1  ir is a CB-table opcode.
- ime  out  1  interrupt master enable.
- halted  out  1  core halted.
- irq_active  out  1  ir holds IRQ_OPCODE for a dispatch.
- irq_idx  out  $clog2(NUM_IRQ)  index of the interrupt being dispatched.
- irq_ack  out  NUM_IRQ  one-hot, one-cycle pulse that clears the IF bit.
- seq_err  out  1  sticky step-overflow error.
- pc_inc_inhibit  out  1  suppress PC increment (see Optional Feature).

Behaviour:
- Reset values (rst=0 at posedge): ir=8'h00, step=0, prefix=0, ime=0, ei_pend=0, halted=0, irq_active=0, irq_idx=0, irq_ack=0, seq_err=0, pc_inc_inhibit=0.
- Reset wins over every other input, including mid-instruction and while halted.
- matched is combinational:
  - NZ: !z
  - Z: z
  - NC: !c
  - C: c
- Priority each cycle: stall > halted handling > done > (is_cond && !matched) > increment.
- stall=1: every register holds, irq_ack=0, and done is ignored.
- Cond fail: step <= next_cond.
- Increment: step <= step+1. If step is at its maximum and done=0, step holds and seq_err is set (sticky until reset).
- On done, step <= 0 and the next IR is selected as follows:
  - a) halt_req=1 (prefix irrelevant): halted <= 1 and ir holds.
  - b) ir==PREFIX_OPCODE && !prefix: ir <= d_in, prefix <= 1. No interrupt is taken between the prefix and its suffix.
  - c) ime && |irq_req: ir <= IRQ_OPCODE, prefix <= 0, irq_active <= 1, irq_idx <= lowest set index, irq_ack <= onehot(irq_idx) for one cycle, ime <= 0.
  - d) otherwise: ir <= d_in, prefix <= 0, irq_active <= 0.
- IME:
  - ime_clr clears ime and ei_pend immediately.
  - ime_set sets ei_pend. ei_pend moves into ime at the done of the following instruction, after the case c) evaluation, so an interrupt is never taken immediately after EI.
  - ime_set and ime_clr together: clr wins.
  - ime_set and ime_clr are sampled only on cycles where stall=0.
- Halted (halted=1):
  - step stays 0 and done is ignored.
  - When |irq_req, halted <= 0 that cycle. If ime=1, apply case c). If ime=0, ir <= d_in (integration keeps the address bus at PC while halted).
- irq_ack is zero on every cycle except the dispatch latch cycle.

Optional Feature:
- Macro: SEQ_HALT_BUG_EN.
- Defined: when halt_req arrives with done while ime=0 and |irq_req is already true, halted is not entered. ir <= d_in and pc_inc_inhibit=1 for the step-0 cycle of that opcode, so the next byte is read twice (SM83 HALT bug).
- Undefined: pc_inc_inhibit is tied to 0, and HALT with ime=0 and a pending request sets halted and exits on the next cycle per the halted rules.

Decomposition:
- Package seq_pkg holds:
  - cond_t and flags_t (moved there from the decoder file)
  - PREFIX_OPCODE and IRQ_OPCODE localparams
  - a STEP_W default constant
- One sub-module, irq_prio_enc: a combinational lowest-index priority encoder, parametrised on NUM_IRQ, with outputs any/idx/onehot.

Test Plan:
- Cond branch: ir=JR NZ (8'h20), flags.z=1, is_cond=1, next_cond=3 at step 0 -> step=3 next cycle. With z=0 -> step=1.
- Stall: assert stall for 3 cycles at step=1 with done=1 -> step/ir unchanged for 3 cycles, then ir<=d_in and step=0 on the cycle stall drops.
- Prefix atomicity: done with ir=8'hCB, d_in=8'h37, ime=1, irq_req=5'b00001 -> ir=8'h37, prefix=1, no irq_ack. The next done dispatches: ir=8'hD3, irq_ack=5'b00001, ime=0.
- EI delay and priority: ime_set at done of EI, irq_req=5'b10100 -> the next instruction executes normally; at its done irq_idx=2, irq_ack=5'b00100.
- HALT wake: halt_req+done with ime=0 -> halted=1. Raise irq_req=5'b01000 -> halted=0, ir<=d_in, no irq_ack (with SEQ_HALT_BUG_EN undefined).
- Overflow and reset: drive step to 7 with done=0 -> step holds at 7, seq_err=1. Assert rst low mid-dispatch -> all outputs return to their reset values the next cycle.
